// File: rtl/line_clear_sequencer.sv
// line_clear_sequencer
//   Runs one line-clear pass over the playfield row store after a piece locks.
//   Rows are read bottom-up. Full rows are counted and dropped. Surviving rows
//   are written back as low as they can go. The vacated top rows are then
//   written with empty cells.
//
// Ports
//   clk, rst_n      game clock, asynchronous active-low reset
//   start           begin a pass (sampled only while idle)
//   busy, done      pass in progress / one-cycle end-of-pass pulse
//   lines_cleared   count of full rows removed (held until next pass starts)
//   cleared_mask    bit r set when original row r was full (held likewise)
//   rd_addr/rd_data row store read port, data one cycle after address
//   wr_en/addr/data row store write port
module line_clear_sequencer #(
  parameter int ROWS   = 20,
  parameter int COLS   = 10,
  parameter int CELL_W = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(ROWS+1)-1:0]  lines_cleared,
  output logic [ROWS-1:0]            cleared_mask,
  output logic [$clog2(ROWS)-1:0]    rd_addr,
  input  logic [COLS*CELL_W-1:0]     rd_data,
  output logic                       wr_en,
  output logic [$clog2(ROWS)-1:0]    wr_addr,
  output logic [COLS*CELL_W-1:0]     wr_data
);

  localparam int AW = $clog2(ROWS);
  localparam int CW = $clog2(ROWS+1);
  // dst carries one extra bit so it can step below row 0 ("exhausted")
  // when no row was cleared, without aliasing a real row address.
  localparam int DW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_EVAL, S_FILL, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   src_q, src_d;
  logic [DW-1:0]   dst_q, dst_d;
  logic [CW-1:0]   lc_q, lc_d;
  logic [ROWS-1:0] mask_q, mask_d;
  logic            row_full;

  // A row is full only when every cell is nonzero.
  always_comb begin
    row_full = 1'b1;
    for (int c = 0; c < COLS; c++)
      if (rd_data[c*CELL_W +: CELL_W] == '0) row_full = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    lc_d    = lc_q;
    mask_d  = mask_q;
    wr_en   = 1'b0;
    wr_addr = dst_q[AW-1:0];
    wr_data = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = AW'(ROWS-1);
          dst_d   = DW'(ROWS-1);
          lc_d    = '0;
          mask_d  = '0;
          state_d = S_READ;
        end
      end
      S_READ: state_d = S_EVAL;
      S_EVAL: begin
        if (row_full) begin
          lc_d          = lc_q + CW'(1);
          mask_d[src_q] = 1'b1;
        end else begin
          // Until the first full row, each surviving row is already in place.
          wr_en   = ({1'b0, src_q} != dst_q);
          wr_data = rd_data;
          dst_d   = dst_q - DW'(1);
        end
        if (src_q == '0) begin
          state_d = (lc_d != '0) ? S_FILL : S_DONE;
        end else begin
          src_d   = src_q - AW'(1);
          state_d = S_READ;
        end
      end
      S_FILL: begin
        // dst enters FILL at lines_cleared-1 and counts down to row 0.
        wr_en = 1'b1;
        dst_d = dst_q - DW'(1);
        if (dst_q == '0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      lc_q    <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      lc_q    <= lc_d;
      mask_q  <= mask_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign rd_addr       = src_q;
  assign lines_cleared = lc_q;
  assign cleared_mask  = mask_q;

endmodule

// File: tb/tb_line_clear_sequencer.sv
// Testbench for line_clear_sequencer: behavioural row store with a
// one-cycle read, a golden compaction model, and a scoreboard of expected
// pass results pushed at start and popped when done is seen.
module tb_line_clear_sequencer;
  localparam int ROWS = 20, COLS = 10, CELL_W = 3;
  localparam int AW = $clog2(ROWS), CW = $clog2(ROWS+1), RW = COLS*CELL_W;

  typedef logic [ROWS-1:0][RW-1:0] field_t;
  typedef struct packed {
    logic [CW-1:0]   lc;
    logic [ROWS-1:0] mask;
    logic [31:0]     lat;
    logic [31:0]     writes;
    field_t          field;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic busy, done, wr_en;
  logic [CW-1:0]   lines_cleared;
  logic [ROWS-1:0] cleared_mask;
  logic [AW-1:0]   rd_addr, wr_addr;
  logic [RW-1:0]   rd_data, wr_data;

  field_t mem, load_val;
  logic   load = 1'b0;
  int     wr_total = 0;
  int     n_cmp = 0, n_bad = 0;
  exp_t   sb[$];

  line_clear_sequencer #(.ROWS(ROWS), .COLS(COLS), .CELL_W(CELL_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .lines_cleared(lines_cleared), .cleared_mask(cleared_mask),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  // Row store: synchronous read, write port, plus a bulk load for setup.
  always @(posedge clk) begin
    if (load) mem <= load_val;
    else if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
    if (wr_en) wr_total <= wr_total + 1;
  end

  function automatic bit is_full(input logic [RW-1:0] row);
    for (int c = 0; c < COLS; c++)
      if (row[c*CELL_W +: CELL_W] == '0) return 1'b0;
    return 1'b1;
  endfunction

  // sparse=0 gives partial rows with exactly one empty cell.
  function automatic logic [RW-1:0] gen_row(input bit full, input bit sparse);
    logic [RW-1:0] row;
    int z;
    for (int c = 0; c < COLS; c++)
      row[c*CELL_W +: CELL_W] = CELL_W'($urandom_range(1, (1 << CELL_W) - 1));
    if (!full) begin
      z = $urandom_range(0, COLS-1);
      row[z*CELL_W +: CELL_W] = '0;
      if (sparse)
        for (int c = 0; c < COLS; c++)
          if ($urandom_range(0, 1) == 0) row[c*CELL_W +: CELL_W] = '0;
    end
    return row;
  endfunction

  function automatic field_t gen_field(input logic [ROWS-1:0] full_rows, input bit sparse);
    field_t f;
    for (int r = 0; r < ROWS; r++) f[r] = gen_row(full_rows[r], sparse);
    return f;
  endfunction

  // Golden model: surviving rows keep their order, stacked from the bottom.
  function automatic field_t compact(input field_t f);
    field_t o = '0;
    int k = ROWS - 1;
    for (int r = ROWS - 1; r >= 0; r--)
      if (!is_full(f[r])) begin o[k] = f[r]; k--; end
    return o;
  endfunction

  function automatic exp_t mk_exp(input field_t f, input int lc, input logic [ROWS-1:0] mask,
                                  input int writes);
    exp_t e;
    e.lc = CW'(lc); e.mask = mask; e.lat = 32'(2*ROWS + lc + 1);
    e.writes = 32'(writes); e.field = compact(f);
    return e;
  endfunction

  // Loads the field, queues the expectation, and presents start for edge T.
  // Returns at the sampling point of cycle T+1.
  task automatic launch(input field_t f, input bit hold, input bit push, input exp_t e);
    @(negedge clk); load = 1'b1; load_val = f;
    @(negedge clk); load = 1'b0;
    if (push) sb.push_back(e);
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  // Bounded wait for done; lat=i means done seen in cycle T+i (-1 on timeout).
  task automatic wait_done(input int pulse_at, input int stop_at, output int lat, output bit drop);
    lat = -1; drop = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      if (i == pulse_at) start = 1'b1;
      else if (pulse_at > 0 && i == pulse_at + 1) start = 1'b0;
      if (stop_at > 0 && i == stop_at) begin lat = i; return; end
      if (done) begin lat = i; return; end
      if (!busy) drop = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #1;
    n_cmp++;
    if ({busy, done, wr_en, lines_cleared, cleared_mask, rd_addr, wr_addr} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b wr_en=%b lc=%0d mask=%h rd=%0d wr=%0d, want all 0",
               busy, done, wr_en, lines_cleared, cleared_mask, rd_addr, wr_addr);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_compaction(input string name, input field_t f, input int lc,
                                 input logic [ROWS-1:0] mask, input int writes);
    exp_t e;
    int lat, w0;
    bit drop;
    w0 = wr_total;
    launch(f, 1'b0, 1'b1, mk_exp(f, lc, mask, writes));
    wait_done(0, 0, lat, drop);
    e = sb.pop_front();
    n_cmp++; if (lat !== int'(e.lat)) begin n_bad++;
      $display("FAIL %s_latency: done at T+%0d, want T+%0d", name, lat, e.lat); end
    n_cmp++; if (drop) begin n_bad++;
      $display("FAIL %s_busy: busy dropped before done, want held high", name); end
    n_cmp++; if (lines_cleared !== e.lc) begin n_bad++;
      $display("FAIL %s_lines: got %0d, want %0d", name, lines_cleared, e.lc); end
    n_cmp++; if (cleared_mask !== e.mask) begin n_bad++;
      $display("FAIL %s_mask: got %h, want %h", name, cleared_mask, e.mask); end
    n_cmp++; if (wr_total - w0 !== int'(e.writes)) begin n_bad++;
      $display("FAIL %s_writes: got %0d, want %0d", name, wr_total - w0, e.writes); end
    n_cmp++; if (mem !== e.field) begin n_bad++;
      $display("FAIL %s_field: got %h, want %h", name, mem, e.field); end
    @(negedge clk);
    n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++;
      $display("FAIL %s_idle: got busy=%b done=%b, want 0 0", name, busy, done); end
  endtask

  task automatic test_midpass_start;
    exp_t e;
    field_t f;
    int lat;
    bit drop;
    f = gen_field('0, 1'b1);
    launch(f, 1'b0, 1'b1, mk_exp(f, 0, '0, 0));
    wait_done(15, 0, lat, drop);
    e = sb.pop_front();
    n_cmp++; if (lat !== int'(e.lat) || drop) begin n_bad++;
      $display("FAIL midpass_start_latency: done at T+%0d drop=%b, want T+%0d drop=0", lat, drop, e.lat); end
    n_cmp++; if (mem !== e.field) begin n_bad++;
      $display("FAIL midpass_start_field: got %h, want %h", mem, e.field); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++;
        $display("FAIL midpass_start_queued: busy=%b %0d cycles after done, want 0", busy, i + 1); end
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    field_t f;
    int lat;
    bit drop;
    f = gen_field(20'h80000, 1'b1);
    launch(f, 1'b1, 1'b1, mk_exp(f, 1, 20'h80000, 20));
    wait_done(0, 0, lat, drop);
    e = sb.pop_front();
    n_cmp++; if (lat !== int'(e.lat) || lines_cleared !== e.lc) begin n_bad++;
      $display("FAIL b2b_first: done T+%0d lc=%0d, want T+%0d lc=%0d", lat, lines_cleared, e.lat, e.lc); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++;
      $display("FAIL b2b_idle_gap: busy=%b in idle cycle, want 0", busy); end
    sb.push_back(mk_exp(compact(f), 0, '0, 0));
    @(negedge clk);
    start = 1'b0;
    wait_done(0, 0, lat, drop);
    e = sb.pop_front();
    n_cmp++; if (lat !== int'(e.lat) || drop) begin n_bad++;
      $display("FAIL b2b_second_latency: done T+%0d drop=%b, want T+%0d drop=0", lat, drop, e.lat); end
    n_cmp++; if (lines_cleared !== e.lc || cleared_mask !== e.mask) begin n_bad++;
      $display("FAIL b2b_second_result: lc=%0d mask=%h, want lc=%0d mask=%h",
               lines_cleared, cleared_mask, e.lc, e.mask); end
    n_cmp++; if (mem !== e.field) begin n_bad++;
      $display("FAIL b2b_second_field: got %h, want %h", mem, e.field); end
    @(negedge clk);
  endtask

  task automatic test_reset_fill;
    field_t f;
    int lat;
    bit drop;
    f = gen_field(20'hB8000, 1'b1);
    launch(f, 1'b0, 1'b0, mk_exp(f, 4, 20'hB8000, 20));
    wait_done(0, 42, lat, drop);
    n_cmp++; if (lat !== 42 || wr_en !== 1'b1 || wr_addr !== AW'(2) || wr_data !== '0) begin n_bad++;
      $display("FAIL rst_fill_inflight: lat=%0d wr_en=%b addr=%0d data=%h, want 42 1 2 0",
               lat, wr_en, wr_addr, wr_data); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy, done, wr_en} !== 3'b000 || lines_cleared !== '0 || cleared_mask !== '0) begin
      n_bad++;
      $display("FAIL rst_fill_async: busy=%b done=%b wr_en=%b lc=%0d mask=%h, want all 0",
               busy, done, wr_en, lines_cleared, cleared_mask); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    test_compaction("post_reset", gen_field(20'hB8000, 1'b1), 4, 20'hB8000, 20);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_compaction("no_full",   gen_field('0, 1'b1),          0,  20'h00000, 0);
    test_compaction("one_full",  gen_field(20'h80000, 1'b1),   1,  20'h80000, 20);
    test_compaction("tetris",    gen_field(20'hB8000, 1'b1),   4,  20'hB8000, 20);
    test_compaction("all_full",  gen_field(20'hFFFFF, 1'b1),   20, 20'hFFFFF, 20);
    test_compaction("one_empty", gen_field('0, 1'b0),          0,  20'h00000, 0);
    test_compaction("all_but_10", gen_field(20'hFFBFF, 1'b0),  19, 20'hFFBFF, 20);
    test_midpass_start();
    test_back_to_back();
    test_reset_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/line_clear_sequencer.md
Name: line_clear_sequencer

Overview:
- Sequences the playfield row memory after a piece locks.
- Scans every row from the bottom up and detects full rows.
- Compacts the surviving rows downward, fills the vacated top rows with empty cells, then reports the number of lines cleared and which rows they were.
- Sits between game_control (issues start, consumes done, lines_cleared and cleared_mask) and the field row store (owns one synchronous read port and one write port).

Parameters:
ROWS, 20, playfield height in rows; row 0 is the top, row ROWS-1 is the bottom.
COLS, 10, cells per row.
CELL_W, 3, bits per cell; a cell value of 0 means empty, any nonzero value means occupied.

Ports:
clk  input  1  game clock (game_clk domain).
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a clear pass; sampled only in IDLE.
busy  output  1  a pass is in progress.
done  output  1  one-cycle pulse marking the end of a pass.
lines_cleared  output  $clog2(ROWS+1)  number of full rows removed; held until the next start is accepted.
cleared_mask  output  ROWS  bit r set when original row r was full; held like lines_cleared.
rd_addr  output  $clog2(ROWS)  row read address.
rd_data  input  COLS*CELL_W  row data; valid the cycle after rd_addr is presented (1-cycle latency).
wr_en  output  1  row write strobe.
wr_addr  output  $clog2(ROWS)  row write address.
wr_data  output  COLS*CELL_W  row write data.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done and wr_en = 0; lines_cleared, cleared_mask, rd_addr and wr_addr = 0. Outputs take these values immediately, without waiting for a clock edge.
- States: IDLE, READ, EVAL, FILL, DONE. Internal pointers: src (row being read) and dst (next row to write). Both are initialised to ROWS-1 when start is accepted; dst may underflow to an "exhausted" state.
- IDLE: if start=1 at edge T, the pass begins:
  - src and dst are loaded with ROWS-1.
  - lines_cleared and cleared_mask are cleared.
  - The state moves to READ.
  - busy=1 from T+1.
- READ: rd_addr=src; next state is EVAL.
- EVAL: rd_data holds row src.
  - Full row (every cell nonzero): increment lines_cleared, set cleared_mask[src]. No write.
  - Non-full row, src != dst: wr_en=1, wr_addr=dst, wr_data=rd_data, decrement dst.
  - Non-full row, src == dst: no write, decrement dst.
  - Next state: if src==0, go to FILL if lines_cleared after this row is greater than 0, otherwise go to DONE. Else decrement src and go to READ.
- FILL: wr_en=1, wr_addr=dst, wr_data=0, decrement dst. The state stays in FILL until exactly lines_cleared rows (rows lines_cleared-1 down to 0) have been written, then goes to DONE.
- DONE: done=1 and busy=1 for this cycle only; next state is IDLE, where busy=0.
- Timing with N cleared rows:
  - READ of row ROWS-1 occurs at T+1.
  - done is high at cycle T+2*ROWS+N+1.
  - Total busy cycles = 2*ROWS+N+1.
- Hazard rule: dst >= src always holds, so a row is never overwritten before it has been read. No stall logic is needed.
- start while busy is ignored, with no queuing. If start is still high in the IDLE cycle after DONE, a new pass begins.
- wr_en is 0 in IDLE, READ and DONE.
- Reset mid-pass aborts immediately. The field store may be left partially compacted; the field owner must reset it alongside.
- A row with a single empty cell is never cleared.
- If all ROWS rows are full: lines_cleared=ROWS and FILL writes every row.

Test Plan:
- No full rows (random partially filled field), start at T: done at T+41, lines_cleared=0, cleared_mask=0, wr_en never asserted, field unchanged.
- Only row 19 full: rows 18..0 copied to rows 19..1, row 0 written as 0; done at T+42; lines_cleared=1; cleared_mask=20'h80000.
- Rows 19, 17, 16, 15 full (tetris case): field matches the golden compaction model; rows 0-3 are zero; lines_cleared=4; cleared_mask=20'hB8000; done at T+45.
- All 20 rows full: lines_cleared=20, cleared_mask=20'hFFFFF, 20 zero writes in FILL, done at T+61. Separately, a row with exactly one empty cell is not cleared.
- start held high continuously: a second pass begins after IDLE. A start pulse injected mid-pass is ignored, and busy never drops early.
- rst_n pulsed low during FILL: busy, done and wr_en go to 0 asynchronously, and lines_cleared=0. After release, a fresh start runs a normal pass.
